// File: rtl/usrt_pkg.sv
// Definitions shared by the USRT receiver and the matching transmitter:
// the frame geometry, the line idle level and the receive FSM encoding.
package usrt_pkg;

   localparam int   DATA_BITS  = 8;
   localparam logic IDLE_LEVEL = 1'b1;
   localparam int   CNT_W      = $clog2(DATA_BITS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_STOP = 2'd2
   } usrt_state_e;

endpackage

// File: rtl/usrt_receiver_if.sv
// Serial input, consumer handshake and status outputs of the USRT receiver.
interface usrt_receiver_if;
   import usrt_pkg::*;

   logic                 si;
   logic                 rx_ack;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_overrun;
   logic                 rx_frame_err;
   logic                 rx_busy;

   modport master (
      output si, rx_ack,
      input  rx_data, rx_valid, rx_overrun, rx_frame_err, rx_busy
   );

   modport slave (
      input  si, rx_ack,
      output rx_data, rx_valid, rx_overrun, rx_frame_err, rx_busy
   );

endinterface

// File: rtl/usrt_rx_holding.sv
// One-byte holding register with valid/overrun tracking and consumer acknowledge.
module usrt_rx_holding
   import usrt_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 accept_i,
   input  logic [DATA_BITS-1:0] byte_i,
   input  logic                 ack_i,
   output logic [DATA_BITS-1:0] data_o,
   output logic                 valid_o,
   output logic                 overrun_o
);

   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 overrun_q, overrun_d;

   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      if (ack_i) begin
         valid_d   = 1'b0;
         overrun_d = 1'b0;
      end
      // An ack in the accept cycle frees the slot, so the new byte wins.
      if (accept_i) begin
         valid_d = 1'b1;
         if (!valid_q || ack_i) begin
            data_d = byte_i;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         data_q    <= data_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
      end
   end

   assign data_o    = data_q;
   assign valid_o   = valid_q;
   assign overrun_o = overrun_q;

endmodule

// File: rtl/usrt_receiver.sv
// Synchronous serial receiver: one sample per clock, start bit, 8 data bits
// LSB first, optional stop-bit check, single-byte holding register.
module usrt_receiver
   import usrt_pkg::*;
#(
   parameter bit CHECK_STOP = 1'b1
) (
   input  logic      clk,
   input  logic      reset,
   usrt_receiver_if.slave rx_if
);

   usrt_state_e          state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 frame_err_q, frame_err_d;
   logic                 accept;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      frame_err_d = 1'b0;
      accept      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rx_if.si != IDLE_LEVEL) begin
               state_d = ST_DATA;
               cnt_d   = '0;
            end
         end
         ST_DATA: begin
            shift_d[cnt_q] = rx_if.si;
            cnt_d          = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            // A low stop bit is consumed here; it never doubles as a start bit.
            state_d = ST_IDLE;
            if ((rx_if.si == IDLE_LEVEL) || !CHECK_STOP) begin
               accept = 1'b1;
            end else begin
               frame_err_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
      end
   end

   usrt_rx_holding u_holding (
      .clk       (clk),
      .reset     (reset),
      .accept_i  (accept),
      .byte_i    (shift_q),
      .ack_i     (rx_if.rx_ack),
      .data_o    (rx_if.rx_data),
      .valid_o   (rx_if.rx_valid),
      .overrun_o (rx_if.rx_overrun)
   );

   assign rx_if.rx_frame_err = frame_err_q;
   assign rx_if.rx_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_usrt_receiver.sv
// Directed bench for usrt_receiver: a table of back-to-back frames plus
// hand-written reset-abort and stop-bit-error sequences.
module tb_usrt_receiver;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic si    = 1'b1;
   logic ack   = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   usrt_receiver_if if1 ();
   usrt_receiver_if if0 ();

   assign if1.si     = si;
   assign if1.rx_ack = ack;
   assign if0.si     = si;
   assign if0.rx_ack = ack;

   usrt_receiver #(.CHECK_STOP(1'b1)) dut1 (.clk(clk), .reset(reset), .rx_if(if1));
   usrt_receiver #(.CHECK_STOP(1'b0)) dut0 (.clk(clk), .reset(reset), .rx_if(if0));

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       ack_start;
      logic       ack_stop;
      logic [7:0] exp_data;
      logic       exp_valid;
      logic       exp_ovr;
      logic       exp_ferr;
   } vec_t;

   vec_t vecs [11];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input logic ack_start,
                             input logic ack_stop, input logic lat_chk);
      si  = 1'b0;
      ack = ack_start;
      step();
      ack = 1'b0;
      chk("busy_after_start", {7'd0, if1.rx_busy}, 8'd1);
      chk("ferr_after_start", {7'd0, if1.rx_frame_err}, 8'd0);
      if (ack_start) begin
         chk("valid_cleared_by_ack", {7'd0, if1.rx_valid}, 8'd0);
         chk("ovr_cleared_by_ack", {7'd0, if1.rx_overrun}, 8'd0);
      end
      for (int i = 0; i < 8; i++) begin
         si = b[i];
         step();
         chk("busy_in_data", {7'd0, if1.rx_busy}, 8'd1);
         if (lat_chk && i == 7) begin
            chk("valid_not_before_k9", {7'd0, if1.rx_valid}, 8'd0);
         end
      end
      si  = stop;
      ack = ack_stop;
      step();
      ack = 1'b0;
      si  = 1'b1;
   endtask

   initial begin
      vecs = '{
         '{8'hA5, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0},
         '{8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0},
         '{8'hC3, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b0},
         '{8'h11, 1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0},
         '{8'h22, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0},
         '{8'h66, 1'b1, 1'b1, 1'b0, 8'h66, 1'b1, 1'b0, 1'b0},
         '{8'h77, 1'b1, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0},
         '{8'h55, 1'b0, 1'b0, 1'b0, 8'h77, 1'b1, 1'b0, 1'b1},
         '{8'h3C, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0},
         '{8'h00, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0},
         '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0}
      };

      // Reset state
      repeat (3) step();
      chk("rst_data", if1.rx_data, 8'h00);
      chk("rst_valid", {7'd0, if1.rx_valid}, 8'd0);
      chk("rst_ovr", {7'd0, if1.rx_overrun}, 8'd0);
      chk("rst_ferr", {7'd0, if1.rx_frame_err}, 8'd0);
      chk("rst_busy", {7'd0, if1.rx_busy}, 8'd0);
      reset = 1'b0;
      step();
      chk("idle_busy", {7'd0, if1.rx_busy}, 8'd0);

      // Table: frames back-to-back, the stop bit being the only idle bit
      for (int v = 0; v < 11; v++) begin
         send_frame(vecs[v].data, vecs[v].stop, vecs[v].ack_start, vecs[v].ack_stop, v == 0);
         chk($sformatf("v%0d_data", v), if1.rx_data, vecs[v].exp_data);
         chk($sformatf("v%0d_valid", v), {7'd0, if1.rx_valid}, {7'd0, vecs[v].exp_valid});
         chk($sformatf("v%0d_ovr", v), {7'd0, if1.rx_overrun}, {7'd0, vecs[v].exp_ovr});
         chk($sformatf("v%0d_ferr", v), {7'd0, if1.rx_frame_err}, {7'd0, vecs[v].exp_ferr});
         chk($sformatf("v%0d_busy", v), {7'd0, if1.rx_busy}, 8'd0);
      end
      ack = 1'b1;
      step();
      ack = 1'b0;
      chk("ack_clears_valid", {7'd0, if1.rx_valid}, 8'd0);
      chk("ack_keeps_data", if1.rx_data, 8'hFF);

      // Reset mid-frame after data bit 3 of 0xFF
      si = 1'b0;
      step();
      for (int i = 0; i < 4; i++) begin
         si = 1'b1;
         step();
      end
      #2 reset = 1'b1;
      #1;
      chk("abort_busy", {7'd0, if1.rx_busy}, 8'd0);
      chk("abort_valid", {7'd0, if1.rx_valid}, 8'd0);
      chk("abort_data", if1.rx_data, 8'h00);
      step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("abort_idle_busy", {7'd0, if1.rx_busy}, 8'd0);
         chk("abort_no_valid", {7'd0, if1.rx_valid}, 8'd0);
         chk("abort_no_ferr", {7'd0, if1.rx_frame_err}, 8'd0);
      end
      send_frame(8'h0F, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("post_abort_data", if1.rx_data, 8'h0F);
      chk("post_abort_valid", {7'd0, if1.rx_valid}, 8'd1);
      chk("post_abort_ovr", {7'd0, if1.rx_overrun}, 8'd0);

      // Bad stop bit: checked instance flags it, unchecked instance accepts
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("bad_stop_ferr", {7'd0, if1.rx_frame_err}, 8'd1);
      chk("bad_stop_valid", {7'd0, if1.rx_valid}, 8'd0);
      chk("bad_stop_busy", {7'd0, if1.rx_busy}, 8'd0);
      chk("nochk_valid", {7'd0, if0.rx_valid}, 8'd1);
      chk("nochk_data", if0.rx_data, 8'h55);
      chk("nochk_ferr", {7'd0, if0.rx_frame_err}, 8'd0);
      step();
      chk("ferr_one_cycle", {7'd0, if1.rx_frame_err}, 8'd0);
      chk("stop_not_start", {7'd0, if1.rx_busy}, 8'd0);
      chk("nochk_idle", {7'd0, if0.rx_busy}, 8'd0);
      step();
      chk("still_idle", {7'd0, if1.rx_busy}, 8'd0);
      chk("still_no_valid", {7'd0, if1.rx_valid}, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/usrt_receiver.md
USRT_RECEIVER -- requirements
Module: usrt_receiver

Interface
REQ-001 Parameter CHECK_STOP, default 1: when 1, the bit after data[7] is checked for idle-high; when 0, it is ignored.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 si  input  1  serial line in the clk domain; idles high; frame = start 0, data[0]..data[7] LSB first, then at least one idle-high bit.
REQ-005 rx_ack  input  1  consumer acknowledge; clears rx_valid and rx_overrun.
REQ-006 rx_data  output  8  last accepted byte.
REQ-007 rx_valid  output  1  rx_data holds an unacknowledged byte.
REQ-008 rx_overrun  output  1  sticky; a good frame was lost because rx_valid was pending.
REQ-009 rx_frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-010 rx_busy  output  1  high while a frame is being received (states DATA, STOP).

Function
REQ-011 The FSM SHALL have states IDLE, DATA and STOP, all registered; si SHALL be sampled once per rising clk edge with no oversampling.
REQ-012 IDLE: si=0 at an edge SHALL go to DATA with the bit counter = 0; si=1 SHALL stay in IDLE.
REQ-013 DATA: each edge SHALL shift si into bit position counter (LSB first) and increment the counter; after the edge that samples bit 7, the FSM SHALL go to STOP.
REQ-014 STOP, si=1 or CHECK_STOP=0: the byte SHALL be accepted and the FSM SHALL return to IDLE.
REQ-015 STOP, si=0 and CHECK_STOP=1: the byte SHALL be discarded and rx_frame_err SHALL pulse high for one cycle. The FSM SHALL return to IDLE; that low bit SHALL NOT count as a start bit.
REQ-016 Latency: if start is sampled at edge k, data bits are sampled at k+1..k+8, the stop bit at k+9, and rx_valid/rx_data SHALL update at edge k+9.
REQ-017 Accept with rx_valid=0, or rx_valid=1 with rx_ack=1 in the same cycle: rx_data SHALL load the new byte, rx_valid SHALL be 1, and rx_overrun SHALL be unchanged (cleared if rx_ack).
REQ-018 Accept with rx_valid=1 and rx_ack=0: rx_data SHALL keep the old byte, rx_valid SHALL stay 1, and rx_overrun SHALL be set.
REQ-019 rx_ack=1 without a simultaneous accept SHALL clear rx_valid and rx_overrun at the next edge; rx_ack while rx_valid=0 SHALL have no effect except clearing rx_overrun.
REQ-020 Back-to-back frames with exactly one idle bit between them SHALL be received without loss.
REQ-021 rx_busy SHALL be combinationally decoded from the state register; all other outputs SHALL be registered.

Reset
REQ-022 Reset SHALL immediately force: state = IDLE, bit counter = 0, shift register = 0x00, rx_data = 0x00, rx_valid = 0, rx_overrun = 0, rx_frame_err = 0, rx_busy = 0.
REQ-023 A reset asserted mid-frame SHALL abandon the frame with no rx_valid or rx_frame_err.
REQ-024 After reset deasserts, the first si=0 sampled SHALL be treated as a start bit.

Structure
REQ-025 Shared package usrt_pkg SHALL hold the FSM state encoding, DATA_BITS=8, and IDLE_LEVEL=1'b1; the matching transmitter shares it.
REQ-026 One sub-module, usrt_rx_holding, SHALL implement the holding register and the rx_valid/rx_overrun/ack logic; the FSM, counter and shift register stay in the top level.

Verification
REQ-027 Byte 0xA5 from the matching transmitter, no ack -> rx_data=0xA5 and rx_valid=1 at start edge +9; rx_overrun=0, rx_frame_err=0.
REQ-028 Frames 0x3C then 0xC3 back-to-back with one idle bit, rx_ack pulsed after the first -> both bytes received in order, no overrun.
REQ-029 Frames 0x11 then 0x22 with no ack -> rx_data stays 0x11 and rx_overrun=1; rx_ack then clears rx_valid and rx_overrun.
REQ-030 Start, 0x55, then stop bit driven 0 with CHECK_STOP=1 -> rx_frame_err pulses for one cycle, rx_valid stays 0, and the FSM returns to IDLE; repeat with CHECK_STOP=0 -> 0x55 accepted.
REQ-031 Reset asserted after data bit 3 of 0xFF, then a clean 0x0F frame -> no output from the aborted frame; 0x0F received correctly.
REQ-032 rx_ack asserted in the same cycle as the accept edge of 0x77 while 0x66 is pending -> rx_data=0x77, rx_valid=1, rx_overrun=0.
